// File: rtl/riscv_pkg.sv
// RV32I shared definitions: opcodes, ALU operation codes, write-back select codes,
// the canonical bubble instruction, and a funct3-to-ALU helper.
package riscv_pkg;

  localparam logic [31:0] NOP_INST = 32'h00000013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_sel_e;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  // funct7[5] selects SRA for both shift forms; it selects SUB only for register-register ops,
  // since for ADDI that bit is part of the immediate.
  function automatic alu_sel_e alu_from_funct(input logic [2:0] funct3, input logic f7b5,
                                              input logic is_op);
    alu_sel_e r;
    r = ALU_ADD;
    case (funct3)
      3'b000:  r = (f7b5 && is_op) ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file, two async read ports and one sync write port; x0 reads zero.
// A same-cycle write to the register being read is bypassed to the read port.
module regfile
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  input  logic            we,
  input  logic [4:0]      rd,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && rd != 5'd0) begin
      regs[rd] <= wd;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1 == 5'd0)                rs1_data = '0;
    else if (we && rd == rs1)       rs1_data = wd;
    else                            rs1_data = regs[rs1];
  end

  always_comb begin
    rs2_data = '0;
    if (rs2 == 5'd0)                rs2_data = '0;
    else if (we && rd == rs2)       rs2_data = wd;
    else                            rs2_data = regs[rs2];
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: decode + register read in ID, one-cycle registered into ID/EX.
// Load-use stalls fetch for one cycle and inserts a bubble; PCSel squashes ID and overrides the stall.
module id_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     ID_Inst,
  input  logic [XLEN-1:0] ID_pc,
  input  logic [XLEN-1:0] ID_pc_plus4,
  input  logic            PCSel,
  input  logic            WB_RegWEn,
  input  logic [4:0]      WB_rd,
  input  logic [XLEN-1:0] WB_data,
  output logic            IF_stall,
  output logic            EX_Valid,
  output logic [31:0]     EX_Inst,
  output logic [XLEN-1:0] EX_pc,
  output logic [XLEN-1:0] EX_pc_plus4,
  output logic [XLEN-1:0] EX_rs1_data,
  output logic [XLEN-1:0] EX_rs2_data,
  output logic [31:0]     EX_imm,
  output logic [4:0]      EX_rs1,
  output logic [4:0]      EX_rs2,
  output logic [4:0]      EX_rd,
  output logic [3:0]      EX_ALUSel,
  output logic            EX_ASel,
  output logic            EX_BSel,
  output logic            EX_BrUn,
  output logic            EX_Branch,
  output logic            EX_Jump,
  output logic            EX_MemRW,
  output logic            EX_MemRd,
  output logic            EX_RegWEn,
  output logic [1:0]      EX_WBSel,
  output logic            ID_Illegal
);

  import riscv_pkg::*;

  logic [6:0]  opcode;
  logic [4:0]  rd_f, rs1_f, rs2_f;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = ID_Inst[6:0];
  assign rd_f   = ID_Inst[11:7];
  assign funct3 = ID_Inst[14:12];
  assign rs1_f  = ID_Inst[19:15];
  assign rs2_f  = ID_Inst[24:20];

  assign imm_i = {{20{ID_Inst[31]}}, ID_Inst[31:20]};
  assign imm_s = {{20{ID_Inst[31]}}, ID_Inst[31:25], ID_Inst[11:7]};
  assign imm_b = {{19{ID_Inst[31]}}, ID_Inst[31], ID_Inst[7], ID_Inst[30:25], ID_Inst[11:8], 1'b0};
  assign imm_u = {ID_Inst[31:12], 12'b0};
  assign imm_j = {{11{ID_Inst[31]}}, ID_Inst[31], ID_Inst[19:12], ID_Inst[20], ID_Inst[30:21], 1'b0};

  logic       legal, use_rs1, use_rs2;
  alu_sel_e   alu_sel;
  logic       a_sel, b_sel, br_un, branch, jump, mem_rw, mem_rd, reg_wen;
  logic [1:0] wb_sel;
  logic [31:0] imm;

  always_comb begin
    legal   = 1'b1;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    alu_sel = ALU_ADD;
    a_sel   = 1'b0;
    b_sel   = 1'b0;
    br_un   = 1'b0;
    branch  = 1'b0;
    jump    = 1'b0;
    mem_rw  = 1'b0;
    mem_rd  = 1'b0;
    reg_wen = 1'b0;
    wb_sel  = WB_ALU;
    imm     = '0;
    case (opcode)
      OPC_LUI: begin
        imm = imm_u; b_sel = 1'b1; alu_sel = ALU_PASS_B; reg_wen = 1'b1;
      end
      OPC_AUIPC: begin
        imm = imm_u; a_sel = 1'b1; b_sel = 1'b1; reg_wen = 1'b1;
      end
      OPC_JAL: begin
        imm = imm_j; a_sel = 1'b1; b_sel = 1'b1; jump = 1'b1; reg_wen = 1'b1; wb_sel = WB_PC4;
      end
      OPC_JALR: begin
        imm = imm_i; b_sel = 1'b1; jump = 1'b1; reg_wen = 1'b1; wb_sel = WB_PC4; use_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        // The ALU computes the target; the comparison itself happens in EX.
        imm = imm_b; a_sel = 1'b1; b_sel = 1'b1; branch = 1'b1; br_un = funct3[1];
        use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_LOAD: begin
        imm = imm_i; b_sel = 1'b1; mem_rd = 1'b1; reg_wen = 1'b1; wb_sel = WB_MEM; use_rs1 = 1'b1;
      end
      OPC_STORE: begin
        imm = imm_s; b_sel = 1'b1; mem_rw = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        imm = imm_i; b_sel = 1'b1; reg_wen = 1'b1; use_rs1 = 1'b1;
        alu_sel = alu_from_funct(funct3, ID_Inst[30], 1'b0);
      end
      OPC_OP: begin
        reg_wen = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        alu_sel = alu_from_funct(funct3, ID_Inst[30], 1'b1);
      end
      default: legal = 1'b0;
    endcase
  end

  logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;

  regfile #(.XLEN(XLEN)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1      (rs1_f),
    .rs2      (rs2_f),
    .rs1_data (rf_rs1_data),
    .rs2_data (rf_rs2_data),
    .we       (WB_RegWEn),
    .rd       (WB_rd),
    .wd       (WB_data)
  );

  logic load_use, bubble;

  assign load_use = EX_Valid && EX_MemRd && (EX_rd != 5'd0) &&
                    ((use_rs1 && EX_rd == rs1_f) || (use_rs2 && EX_rd == rs2_f));
  assign IF_stall   = load_use && !PCSel;
  assign bubble     = PCSel || load_use || !legal;
  assign ID_Illegal = !legal;

  always_ff @(posedge clk) begin
    if (!rst || bubble) begin
      EX_Valid    <= 1'b0;
      EX_Inst     <= NOP_INST;
      EX_pc       <= '0;
      EX_pc_plus4 <= '0;
      EX_rs1_data <= '0;
      EX_rs2_data <= '0;
      EX_imm      <= '0;
      EX_rs1      <= '0;
      EX_rs2      <= '0;
      EX_rd       <= '0;
      EX_ALUSel   <= ALU_ADD;
      EX_ASel     <= 1'b0;
      EX_BSel     <= 1'b0;
      EX_BrUn     <= 1'b0;
      EX_Branch   <= 1'b0;
      EX_Jump     <= 1'b0;
      EX_MemRW    <= 1'b0;
      EX_MemRd    <= 1'b0;
      EX_RegWEn   <= 1'b0;
      // Reset leaves the ALU path selected; a bubble clears everything.
      EX_WBSel    <= !rst ? WB_ALU : WB_MEM;
    end else begin
      EX_Valid    <= 1'b1;
      EX_Inst     <= ID_Inst;
      EX_pc       <= ID_pc;
      EX_pc_plus4 <= ID_pc_plus4;
      EX_rs1_data <= use_rs1 ? rf_rs1_data : '0;
      EX_rs2_data <= use_rs2 ? rf_rs2_data : '0;
      EX_imm      <= imm;
      EX_rs1      <= use_rs1 ? rs1_f : 5'd0;
      EX_rs2      <= use_rs2 ? rs2_f : 5'd0;
      EX_rd       <= reg_wen ? rd_f : 5'd0;
      EX_ALUSel   <= alu_sel;
      EX_ASel     <= a_sel;
      EX_BSel     <= b_sel;
      EX_BrUn     <= br_un;
      EX_Branch   <= branch;
      EX_Jump     <= jump;
      EX_MemRW    <= mem_rw;
      EX_MemRd    <= mem_rd;
      EX_RegWEn   <= reg_wen;
      EX_WBSel    <= wb_sel;
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: driver pushes expected ID/EX contents, a monitor pops and compares.
module tb_id_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ID_Inst = NOP_INST, ID_pc = '0, ID_pc_plus4 = '0;
  logic        PCSel = 1'b0, WB_RegWEn = 1'b0;
  logic [4:0]  WB_rd = '0;
  logic [31:0] WB_data = '0;
  logic        IF_stall, EX_Valid, EX_ASel, EX_BSel, EX_BrUn, EX_Branch, EX_Jump;
  logic        EX_MemRW, EX_MemRd, EX_RegWEn, ID_Illegal;
  logic [31:0] EX_Inst, EX_pc, EX_pc_plus4, EX_rs1_data, EX_rs2_data, EX_imm;
  logic [4:0]  EX_rs1, EX_rs2, EX_rd;
  logic [3:0]  EX_ALUSel;
  logic [1:0]  EX_WBSel;

  always #5 clk = ~clk;

  id_stage #(.XLEN(32), .NOP_INST(32'h00000013)) dut (
    .clk(clk), .rst(rst), .ID_Inst(ID_Inst), .ID_pc(ID_pc), .ID_pc_plus4(ID_pc_plus4),
    .PCSel(PCSel), .WB_RegWEn(WB_RegWEn), .WB_rd(WB_rd), .WB_data(WB_data),
    .IF_stall(IF_stall), .EX_Valid(EX_Valid), .EX_Inst(EX_Inst), .EX_pc(EX_pc),
    .EX_pc_plus4(EX_pc_plus4), .EX_rs1_data(EX_rs1_data), .EX_rs2_data(EX_rs2_data),
    .EX_imm(EX_imm), .EX_rs1(EX_rs1), .EX_rs2(EX_rs2), .EX_rd(EX_rd), .EX_ALUSel(EX_ALUSel),
    .EX_ASel(EX_ASel), .EX_BSel(EX_BSel), .EX_BrUn(EX_BrUn), .EX_Branch(EX_Branch),
    .EX_Jump(EX_Jump), .EX_MemRW(EX_MemRW), .EX_MemRd(EX_MemRd), .EX_RegWEn(EX_RegWEn),
    .EX_WBSel(EX_WBSel), .ID_Illegal(ID_Illegal)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] inst, pc, pc4, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu;
    logic        asel, bsel, brun, branch, jump, memrw, memrd, regwen;
    logic [1:0]  wbsel;
  } ex_t;

  ex_t   exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic ex_t reset_ex();
    ex_t e = '0;
    e.inst = 32'h00000013;
    e.wbsel = 2'd1;
    return e;
  endfunction

  function automatic ex_t bubble_ex();
    ex_t e = '0;
    e.inst = 32'h00000013;
    return e;
  endfunction

  function automatic ex_t base(input logic [31:0] inst, input logic [31:0] pc);
    ex_t e = '0;
    e.valid = 1'b1; e.inst = inst; e.pc = pc; e.pc4 = pc + 32'd4; e.wbsel = 2'd1;
    return e;
  endfunction

  task automatic step(input logic r, input logic [31:0] inst, input logic [31:0] pc,
                      input logic pcsel, input logic we, input logic [4:0] wrd,
                      input logic [31:0] wdat, input logic exp_stall, input logic exp_ill,
                      input ex_t e, input string nm);
    @(negedge clk);
    rst = r; ID_Inst = inst; ID_pc = pc; ID_pc_plus4 = pc + 32'd4; PCSel = pcsel;
    WB_RegWEn = we; WB_rd = wrd; WB_data = wdat;
    #1;
    checks++;
    if (IF_stall !== exp_stall || ID_Illegal !== exp_ill) begin
      errors++;
      $display("FAIL %s comb: IF_stall=%b ID_Illegal=%b, expected %b %b", nm, IF_stall,
               ID_Illegal, exp_stall, exp_ill);
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: every posedge consumes one expected ID/EX image if one is pending.
  initial begin
    ex_t e, got;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        got = {EX_Valid, EX_Inst, EX_pc, EX_pc_plus4, EX_rs1_data, EX_rs2_data, EX_imm,
               EX_rs1, EX_rs2, EX_rd, EX_ALUSel, EX_ASel, EX_BSel, EX_BrUn, EX_Branch,
               EX_Jump, EX_MemRW, EX_MemRd, EX_RegWEn, EX_WBSel};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL %s ex: got valid=%b inst=%h rs1d=%h rs2d=%h imm=%h rd=%0d all=%h, expected valid=%b inst=%h rs1d=%h rs2d=%h imm=%h rd=%0d all=%h",
                   nm, got.valid, got.inst, got.rs1d, got.rs2d, got.imm, got.rd, got,
                   e.valid, e.inst, e.rs1d, e.rs2d, e.imm, e.rd, e);
        end
      end
    end
  end

  initial begin
    ex_t e;
    @(posedge clk);
    step(0, NOP_INST, 32'h0, 0, 0, 5'd0, 32'h0, 0, 0, reset_ex(), "reset0");
    step(0, NOP_INST, 32'h0, 0, 0, 5'd0, 32'h0, 0, 0, reset_ex(), "reset1");

    // add x7,x5,x5 : x5 is zero after reset
    e = base(32'h005283B3, 32'h1000);
    e.rs1 = 5; e.rs2 = 5; e.rd = 7; e.alu = ALU_ADD; e.regwen = 1;
    step(1, 32'h005283B3, 32'h1000, 0, 0, 5'd0, 32'h0, 0, 0, e, "read_x5");

    // addi x1,x0,5 with a concurrent write to x0 that must not bypass
    e = base(32'h00500093, 32'h1004);
    e.imm = 32'd5; e.rd = 1; e.bsel = 1; e.regwen = 1; e.alu = ALU_ADD;
    step(1, 32'h00500093, 32'h1004, 0, 1, 5'd0, 32'hFFFFFFFF, 0, 0, e, "addi");

    // add x4,x3,x3 with write-through of x3
    e = base(32'h00318233, 32'h1008);
    e.rs1d = 32'hDEADBEEF; e.rs2d = 32'hDEADBEEF; e.rs1 = 3; e.rs2 = 3; e.rd = 4;
    e.alu = ALU_ADD; e.regwen = 1;
    step(1, 32'h00318233, 32'h1008, 0, 1, 5'd3, 32'hDEADBEEF, 0, 0, e, "wthru");

    // sub x5,x3,x0 reads the stored x3; writes x1=0x100 meanwhile
    e = base(32'h400182B3, 32'h100C);
    e.rs1d = 32'hDEADBEEF; e.rs1 = 3; e.rd = 5; e.alu = ALU_SUB; e.regwen = 1;
    step(1, 32'h400182B3, 32'h100C, 0, 1, 5'd1, 32'h00000100, 0, 0, e, "sub");

    // lw x2,0(x1)
    e = base(32'h0000A103, 32'h1010);
    e.rs1d = 32'h100; e.rs1 = 1; e.rd = 2; e.bsel = 1; e.memrd = 1; e.regwen = 1; e.wbsel = 2'd0;
    step(1, 32'h0000A103, 32'h1010, 0, 0, 5'd0, 32'h0, 0, 0, e, "lw");

    // add x3,x2,x1 right behind the load: stall and bubble, then reissue
    step(1, 32'h001101B3, 32'h1014, 0, 0, 5'd0, 32'h0, 1, 0, bubble_ex(), "loaduse");
    e = base(32'h001101B3, 32'h1014);
    e.rs2d = 32'h100; e.rs1 = 2; e.rs2 = 1; e.rd = 3; e.alu = ALU_ADD; e.regwen = 1;
    step(1, 32'h001101B3, 32'h1014, 0, 0, 5'd0, 32'h0, 0, 0, e, "reissue");

    e = base(32'h0000A103, 32'h1018);
    e.rs1d = 32'h100; e.rs1 = 1; e.rd = 2; e.bsel = 1; e.memrd = 1; e.regwen = 1; e.wbsel = 2'd0;
    step(1, 32'h0000A103, 32'h1018, 0, 0, 5'd0, 32'h0, 0, 0, e, "lw2");

    // lui x5,0x10 : rs1 field encodes x2 but LUI reads nothing, so no stall
    e = base(32'h000102B7, 32'h101C);
    e.imm = 32'h00010000; e.rd = 5; e.bsel = 1; e.alu = ALU_PASS_B; e.regwen = 1;
    step(1, 32'h000102B7, 32'h101C, 0, 0, 5'd0, 32'h0, 0, 0, e, "lui_nostall");

    e = base(32'h0000A103, 32'h1020);
    e.rs1d = 32'h100; e.rs1 = 1; e.rd = 2; e.bsel = 1; e.memrd = 1; e.regwen = 1; e.wbsel = 2'd0;
    step(1, 32'h0000A103, 32'h1020, 0, 0, 5'd0, 32'h0, 0, 0, e, "lw3");

    // beq x1,x2,-8 under flush with a load-use hazard pending
    step(1, 32'hFE208CE3, 32'h1024, 1, 0, 5'd0, 32'h0, 0, 0, bubble_ex(), "flush");

    e = base(32'hFE208CE3, 32'h1028);
    e.rs1d = 32'h100; e.imm = 32'hFFFFFFF8; e.rs1 = 1; e.rs2 = 2; e.asel = 1; e.bsel = 1;
    e.branch = 1; e.alu = ALU_ADD;
    step(1, 32'hFE208CE3, 32'h1028, 0, 0, 5'd0, 32'h0, 0, 0, e, "beq");

    // jal x1,-4
    e = base(32'hFFDFF0EF, 32'h102C);
    e.imm = 32'hFFFFFFFC; e.rd = 1; e.asel = 1; e.bsel = 1; e.jump = 1; e.regwen = 1;
    e.wbsel = 2'd2; e.alu = ALU_ADD;
    step(1, 32'hFFDFF0EF, 32'h102C, 0, 0, 5'd0, 32'h0, 0, 0, e, "jal");

    step(1, 32'h00000000, 32'h1030, 0, 0, 5'd0, 32'h0, 0, 1, bubble_ex(), "illegal");

    // add x6,x0,x0 : x0 still zero after the earlier write attempt
    e = base(32'h00000333, 32'h1034);
    e.rd = 6; e.alu = ALU_ADD; e.regwen = 1;
    step(1, 32'h00000333, 32'h1034, 0, 0, 5'd0, 32'h0, 0, 0, e, "read_x0");

    // reset mid-stream beats a concurrent write-back to x7 and wipes x1
    step(0, 32'h00700393, 32'h1038, 1, 1, 5'd7, 32'h00001234, 0, 0, reset_ex(), "midreset");

    e = base(32'h00738433, 32'h103C);
    e.rs1 = 7; e.rs2 = 7; e.rd = 8; e.alu = ALU_ADD; e.regwen = 1;
    step(1, 32'h00738433, 32'h103C, 0, 0, 5'd0, 32'h0, 0, 0, e, "post_reset_x7");

    e = base(32'h00008513, 32'h1040); // addi x10,x1,0 : x1 cleared by reset
    e.rs1 = 1; e.rd = 10; e.bsel = 1; e.alu = ALU_ADD; e.regwen = 1;
    step(1, 32'h00008513, 32'h1040, 0, 0, 5'd0, 32'h0, 0, 0, e, "post_reset_x1");

    @(negedge clk);
    WB_RegWEn = 1'b0;
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I decode stage, directly downstream of the fetch stage.
- Consumes the fetch stage's IF/ID outputs (ID_Inst, ID_pc, ID_pc_plus4).
- Reads the 32x32 register file, generates the immediate and control signals, and registers everything into the ID/EX pipeline register.
- Detects load-use hazards (stalls fetch) and squashes on taken branch/jump (PCSel).

Parameters:
- XLEN, 32, datapath width.
- NOP_INST, 32'h00000013, instruction reported for bubbles (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (0 = reset)
- ID_Inst  in  32  instruction from fetch
- ID_pc  in  32  PC of ID_Inst
- ID_pc_plus4  in  32  ID_pc+4
- PCSel  in  1  taken branch/jump resolved in EX; squash ID
- WB_RegWEn  in  1  write-back enable
- WB_rd  in  5  write-back destination
- WB_data  in  32  write-back data
- IF_stall  out  1  hold PC and IF/ID register this cycle (combinational)
- EX_Valid  out  1  ID/EX holds a real instruction
- EX_Inst  out  32  instruction in EX (NOP_INST for bubbles)
- EX_pc, EX_pc_plus4  out  32 each  carried PCs
- EX_rs1_data, EX_rs2_data  out  32 each  register operands
- EX_imm  out  32  sign-extended immediate
- EX_rs1, EX_rs2, EX_rd  out  5 each  register indices (for forwarding)
- EX_ALUSel  out  4  ALU op (package enum)
- EX_ASel  out  1  0=rs1, 1=pc
- EX_BSel  out  1  0=rs2, 1=imm
- EX_BrUn  out  1  unsigned branch compare
- EX_Branch, EX_Jump  out  1 each  conditional branch / JAL-JALR
- EX_MemRW  out  1  1=store
- EX_MemRd  out  1  1=load
- EX_RegWEn  out  1  writes rd
- EX_WBSel  out  2  0=mem, 1=alu, 2=pc+4
- ID_Illegal  out  1  unsupported opcode in ID (combinational)

Behaviour:
- Reset (rst==0 at posedge): all EX_* registers cleared to 0, except EX_Inst=NOP_INST and EX_WBSel=1. EX_Valid=0. Register file x1..x31 cleared to 0.
- Latency: one cycle. Decode and register read are combinational in ID; results appear on EX_* after the next posedge.
- Register file:
  - 2 async read ports, 1 sync write port.
  - x0 reads 0; writes to x0 are ignored.
  - Write-through: if WB_RegWEn && WB_rd!=0 && WB_rd==rs, the read returns WB_data in the same cycle.
- Immediates (I/S/B/U/J formats) are sign-extended per RV32I. R-type immediate = 0.
- Decode:
  - Opcodes supported: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Any other opcode: ID_Illegal=1 and the instruction enters EX as a bubble.
  - SRAI/SUB are selected by funct7[5].
  - LUI uses ALUSel=PASS_B.
- Register use:
  - rs1 is used by all formats except LUI, AUIPC and JAL.
  - rs2 is used by R, S and B formats only.
  - Unused indices are driven to 0 on EX_rs1/EX_rs2.
- Load-use hazard:
  - Condition: EX_Valid && EX_MemRd && EX_rd!=0 && (EX_rd==rs1 used || EX_rd==rs2 used).
  - Response: IF_stall=1 and ID/EX loads a bubble.
  - Fetch holds its outputs, so the instruction re-decodes next cycle. A stall lasts exactly 1 cycle.
- Flush:
  - PCSel=1: ID/EX loads a bubble and IF_stall is forced 0.
  - Flush has priority over stall.
- Bubble: EX_Valid=0, EX_RegWEn=0, EX_MemRW=0, EX_MemRd=0, EX_Branch=0, EX_Jump=0, EX_Inst=NOP_INST. Other fields are don't-care but are driven 0.
- Reset mid-operation: reset overrides flush, stall and write-back, including any register file write that cycle.

Decomposition:
- Package riscv_pkg holds:
  - opcode localparams;
  - ALUSel enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B);
  - WBSel codes;
  - NOP_INST.
- Sub-module regfile: 32x32, 2R/1W, x0 hardwired, write-through bypass, synchronous active-low reset.
- Decode and immediate generation stay inline as combinational logic.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> EX_Valid=0, EX_Inst=32'h00000013, IF_stall=0. After rst=1, reading x5 returns 0.
- addi x1,x0,5 (32'h00500093) -> next cycle EX_imm=5, EX_rd=1, EX_BSel=1, EX_RegWEn=1, EX_ALUSel=ADD, EX_Valid=1.
- Write-through: WB_RegWEn=1, WB_rd=3, WB_data=32'hDEADBEEF, same cycle as add x4,x3,x3 -> EX_rs1_data=EX_rs2_data=32'hDEADBEEF. A WB write to x0 -> later read of x0 returns 0.
- Load-use: lw x2,0(x1) in EX, then add x3,x2,x1 in ID -> IF_stall=1 for one cycle, bubble in EX, then the add issues. Using x2 only via an LUI in ID -> no stall.
- Flush: PCSel=1 while beq x1,x2,-8 (32'hFE208CE3) is in ID -> EX_Valid=0, IF_stall=0 even if a load-use hazard is present.
- Immediate/illegal: jal x1,-4 (32'hFFDFF0EF) -> EX_imm=32'hFFFFFFFC, EX_WBSel=2, EX_Jump=1. Opcode 7'b0000000 -> ID_Illegal=1 and a bubble enters EX.
